// File: rtl/cp0_bypass_tracker_pkg.sv
// Shared CP0 bypass definitions: register address/select widths and the slot tag record.
package cp0_bypass_tracker_pkg;

  localparam int unsigned CP0_ADDR_W = 5;
  localparam int unsigned CP0_SEL_W  = 3;
  localparam int unsigned CP0_DATA_W = 32;
  localparam int unsigned CNT_W      = 4;

  typedef struct packed {
    logic                  valid;
    logic [CP0_ADDR_W-1:0] addr;
    logic [CP0_SEL_W-1:0]  sel;
  } cp0_tag_t;

  // A source contributes to a read only when it is live and names the same register/select.
  function automatic logic tag_match(input cp0_tag_t              t,
                                     input logic [CP0_ADDR_W-1:0] a,
                                     input logic [CP0_SEL_W-1:0]  s);
    return t.valid && (t.addr == a) && (t.sel == s);
  endfunction

endpackage

// File: rtl/cp0_bypass_tracker_mask_merge.sv
// One masked-merge link of the read bypass chain: masked bits of i_data replace i_v on a hit.
module cp0_mask_merge #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_v,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_mask,
  input  logic              i_hit,
  output logic [DATA_W-1:0] o_v_c
);

  assign o_v_c = i_hit ? ((i_v & ~i_mask) | (i_data & i_mask)) : i_v;

endmodule

// File: rtl/cp0_bypass_tracker.sv
// Tracks in-flight CP0 writes between capture and commit and forwards their masked data to ID-stage reads.
module cp0_bypass_tracker
  import cp0_bypass_tracker_pkg::*;
#(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned DATA_W = CP0_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [CP0_ADDR_W-1:0] in_addr,
  input  logic [CP0_SEL_W-1:0]  in_sel,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [DATA_W-1:0]     in_mask,
  input  logic                  advance,
  input  logic                  flush,
  input  logic [CP0_ADDR_W-1:0] rd_addr,
  input  logic [CP0_SEL_W-1:0]  rd_sel,
  input  logic [DATA_W-1:0]     cp0_val,
  output logic [DATA_W-1:0]     rd_val,
  output logic                  rd_hit,
  output logic                  commit_we,
  output logic [CP0_ADDR_W-1:0] commit_addr,
  output logic [CP0_SEL_W-1:0]  commit_sel,
  output logic [DATA_W-1:0]     commit_data,
  output logic [DATA_W-1:0]     commit_mask,
  output logic [CNT_W-1:0]      pending_cnt
);

  cp0_tag_t          r_tag  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DATA_W-1:0] r_mask [DEPTH];

  logic [CNT_W-1:0]  w_pending_nxt;
  logic [DATA_W-1:0] w_chain [DEPTH+2];
  logic [DEPTH:0]    w_hit;

  // Occupancy after the coming edge, registered so pending_cnt mirrors the slot valid bits.
  always_comb begin
    w_pending_nxt = '0;
    if (!flush) begin
      if (advance) begin
        w_pending_nxt = CNT_W'(in_valid);
        for (int unsigned k = 0; k < DEPTH - 1; k++) begin
          w_pending_nxt = w_pending_nxt + CNT_W'(r_tag[k].valid);
        end
      end else begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          w_pending_nxt = w_pending_nxt + CNT_W'(r_tag[k].valid);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_tag[k]  <= '0;
        r_data[k] <= '0;
        r_mask[k] <= '0;
      end
      commit_we   <= 1'b0;
      commit_addr <= '0;
      commit_sel  <= '0;
      commit_data <= '0;
      commit_mask <= '0;
      pending_cnt <= '0;
    end else begin
      if (advance) begin
        commit_we   <= r_tag[DEPTH-1].valid;
        commit_addr <= r_tag[DEPTH-1].addr;
        commit_sel  <= r_tag[DEPTH-1].sel;
        commit_data <= r_data[DEPTH-1];
        commit_mask <= r_mask[DEPTH-1];
        for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
          r_tag[k]  <= r_tag[k-1];
          r_data[k] <= r_data[k-1];
          r_mask[k] <= r_mask[k-1];
        end
        r_tag[0]  <= '{valid: in_valid, addr: in_addr, sel: in_sel};
        r_data[0] <= in_data;
        r_mask[0] <= in_mask;
      end else begin
        commit_we <= 1'b0;
      end
      // Flush overrides the shift: the oldest entry above has already been handed to commit.
      if (flush) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          r_tag[k].valid <= 1'b0;
        end
      end
      pending_cnt <= w_pending_nxt;
    end
  end

  // Merge chain runs oldest to youngest so younger writes win in their masked bits.
  assign w_chain[0] = cp0_val;
  assign w_hit[0]   = commit_we && (commit_addr == rd_addr) && (commit_sel == rd_sel);

  cp0_mask_merge #(.DATA_W(DATA_W)) u_merge_commit (
    .i_v    (w_chain[0]),
    .i_data (commit_data),
    .i_mask (commit_mask),
    .i_hit  (w_hit[0]),
    .o_v_c  (w_chain[1])
  );

  for (genvar j = 0; j < DEPTH; j++) begin : g_slot_merge
    localparam int unsigned S = DEPTH - 1 - j;
    assign w_hit[j+1] = tag_match(r_tag[S], rd_addr, rd_sel);
    cp0_mask_merge #(.DATA_W(DATA_W)) u_merge (
      .i_v    (w_chain[j+1]),
      .i_data (r_data[S]),
      .i_mask (r_mask[S]),
      .i_hit  (w_hit[j+1]),
      .o_v_c  (w_chain[j+2])
    );
  end

  assign rd_val = w_chain[DEPTH+1];
  assign rd_hit = |w_hit;

endmodule

// File: tb/tb_cp0_bypass_tracker.sv
// Directed bench for cp0_bypass_tracker (DEPTH=3, DATA_W=32) with hand-computed expectations.
module tb_cp0_bypass_tracker;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  in_addr;
  logic [2:0]  in_sel;
  logic [31:0] in_data;
  logic [31:0] in_mask;
  logic        advance;
  logic        flush;
  logic [4:0]  rd_addr;
  logic [2:0]  rd_sel;
  logic [31:0] cp0_val;
  logic [31:0] rd_val;
  logic        rd_hit;
  logic        commit_we;
  logic [4:0]  commit_addr;
  logic [2:0]  commit_sel;
  logic [31:0] commit_data;
  logic [31:0] commit_mask;
  logic [3:0]  pending_cnt;

  int vectors;
  int miscompares;

  cp0_bypass_tracker #(.DEPTH(3), .DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_addr     (in_addr),
    .in_sel      (in_sel),
    .in_data     (in_data),
    .in_mask     (in_mask),
    .advance     (advance),
    .flush       (flush),
    .rd_addr     (rd_addr),
    .rd_sel      (rd_sel),
    .cp0_val     (cp0_val),
    .rd_val      (rd_val),
    .rd_hit      (rd_hit),
    .commit_we   (commit_we),
    .commit_addr (commit_addr),
    .commit_sel  (commit_sel),
    .commit_data (commit_data),
    .commit_mask (commit_mask),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_addr  = 5'd0;
    in_sel   = 3'd0;
    in_data  = 32'h0;
    in_mask  = 32'h0;
    advance  = 1'b0;
    flush    = 1'b0;
    rd_addr  = 5'd12;
    rd_sel   = 3'd0;
    cp0_val  = 32'h1234_5678;

    // Reset state
    @(negedge clk);
    chk("rst_rd_val", rd_val, 32'h1234_5678);
    chk("rst_rd_hit", 32'(rd_hit), 32'd0);
    chk("rst_pending", 32'(pending_cnt), 32'd0);
    chk("rst_commit_we", 32'(commit_we), 32'd0);
    rst_n = 1'b1;
    next_edge();

    // Single write travels the pipe: visible DEPTH+1 cycles, commits once DEPTH cycles after capture
    cp0_val  = 32'h0;
    in_valid = 1'b1;
    in_addr  = 5'd12;
    in_sel   = 3'd0;
    in_data  = 32'hFFFF_FFFF;
    in_mask  = 32'h0000_00FF;
    advance  = 1'b1;
    next_edge();
    in_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("walk%0d_rd_val", i), rd_val, (i <= 4) ? 32'h0000_00FF : 32'h0);
      chk($sformatf("walk%0d_rd_hit", i), 32'(rd_hit), (i <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("walk%0d_commit_we", i), 32'(commit_we), (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("walk%0d_pending", i), 32'(pending_cnt), (i <= 3) ? 32'd1 : 32'd0);
      if (i == 4) begin
        chk("walk_commit_mask", commit_mask, 32'h0000_00FF);
        chk("walk_commit_addr", 32'(commit_addr), 32'd12);
      end
      next_edge();
    end

    // Two back-to-back writes with disjoint masks
    in_valid = 1'b1;
    in_data  = 32'hAAAA_AAAA;
    in_mask  = 32'hFFFF_0000;
    next_edge();
    in_data  = 32'h5555_5555;
    in_mask  = 32'h0000_FFFF;
    next_edge();
    in_valid = 1'b0;
    advance  = 1'b0;
    @(negedge clk);
    chk("disjoint_rd_val", rd_val, 32'hAAAA_5555);
    chk("disjoint_pending", 32'(pending_cnt), 32'd2);

    // Hold with two entries pending; in_valid must be ignored while held
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      next_edge();
      @(negedge clk);
      chk($sformatf("hold%0d_pending", i), 32'(pending_cnt), 32'd2);
      chk($sformatf("hold%0d_commit_we", i), 32'(commit_we), 32'd0);
    end
    chk("hold_rd_val", rd_val, 32'hAAAA_5555);
    rd_sel  = 3'd1;
    cp0_val = 32'hDEAD_BEEF;
    #1;
    chk("sel_miss_rd_val", rd_val, 32'hDEAD_BEEF);
    chk("sel_miss_rd_hit", 32'(rd_hit), 32'd0);
    rd_sel  = 3'd0;
    cp0_val = 32'h0;
    in_valid = 1'b0;

    // Asynchronous reset in the middle of the hold
    rst_n = 1'b0;
    #1;
    chk("async_pending", 32'(pending_cnt), 32'd0);
    chk("async_commit_we", 32'(commit_we), 32'd0);
    chk("async_rd_val", rd_val, 32'h0);
    chk("async_rd_hit", 32'(rd_hit), 32'd0);
    chk("async_commit_data", commit_data, 32'h0);
    chk("async_commit_mask", commit_mask, 32'h0);
    chk("async_commit_addr", 32'(commit_addr), 32'd0);
    #1;
    rst_n = 1'b1;
    next_edge();
    chk("post_rst_commit_we", 32'(commit_we), 32'd0);

    // Overlapping full masks: younger wins
    advance  = 1'b1;
    in_valid = 1'b1;
    in_mask  = 32'hFFFF_FFFF;
    in_data  = 32'h1;
    next_edge();
    in_data  = 32'h2;
    next_edge();
    @(negedge clk);
    chk("overlap_rd_val", rd_val, 32'h2);

    // Third entry fills every slot
    in_data = 32'h3;
    next_edge();
    @(negedge clk);
    chk("full_pending", 32'(pending_cnt), 32'd3);
    chk("full_rd_val", rd_val, 32'h3);

    // Flush with advance: oldest still commits, slots empty
    flush = 1'b1;
    in_data = 32'h4;
    next_edge();
    flush    = 1'b0;
    in_valid = 1'b0;
    advance  = 1'b0;
    @(negedge clk);
    chk("flush_commit_we", 32'(commit_we), 32'd1);
    chk("flush_commit_data", commit_data, 32'h1);
    chk("flush_pending", 32'(pending_cnt), 32'd0);
    chk("flush_rd_val", rd_val, 32'h1);
    next_edge();
    @(negedge clk);
    chk("after_flush_rd_hit", 32'(rd_hit), 32'd0);
    chk("after_flush_commit_we", 32'(commit_we), 32'd0);
    chk("after_flush_pending", 32'(pending_cnt), 32'd0);

    // Zero-mask write occupies a slot and hits without changing the value
    cp0_val  = 32'hCAFE_F00D;
    advance  = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    in_mask  = 32'h0;
    next_edge();
    in_valid = 1'b0;
    advance  = 1'b0;
    @(negedge clk);
    chk("zmask_rd_val", rd_val, 32'hCAFE_F00D);
    chk("zmask_rd_hit", 32'(rd_hit), 32'd1);
    chk("zmask_pending", 32'(pending_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cp0_bypass_tracker.md
CP0_BYPASS_TRACKER -- requirements
Module: cp0_bypass_tracker

Interface
REQ-001 Parameter DEPTH, default 3, number of in-flight pipeline slots between capture and commit (legal 1..8).
REQ-002 Parameter DATA_W, default 32, CP0 register data width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  CP0 write entering slot 0 this cycle.
REQ-006 in_addr  input  5  destination CP0 register number.
REQ-007 in_sel  input  3  destination CP0 select.
REQ-008 in_data  input  DATA_W  write data.
REQ-009 in_mask  input  DATA_W  per-bit write enable; 1 = bit written.
REQ-010 advance  input  1  pipeline advances this cycle; 0 = hold all slots.
REQ-011 flush  input  1  squash all in-flight slots (exception/ERET).
REQ-012 rd_addr  input  5  CP0 register number being read.
REQ-013 rd_sel  input  3  CP0 select being read.
REQ-014 cp0_val  input  DATA_W  architectural value from CP0 file.
REQ-015 rd_val  output  DATA_W  bypassed read value, combinational.
REQ-016 rd_hit  output  1  at least one valid source matched the read.
REQ-017 commit_we  output  1  registered commit strobe to CP0 file.
REQ-018 commit_addr / commit_sel / commit_data / commit_mask  output  5/3/DATA_W/DATA_W  registered commit fields.
REQ-019 pending_cnt  output  4  registered count of valid slots.

Function
REQ-020 Slots 0..DEPTH-1 each hold {valid, addr, sel, data, mask}; slot 0 youngest, slot DEPTH-1 oldest.
REQ-021 advance=1, flush=0: slot k+1 loads slot k; slot 0 loads {in_valid, in_*}; slot DEPTH-1 content moves to the commit register.
REQ-022 advance=0, flush=0: all slots and commit fields hold; commit_we deasserts next cycle; in_valid ignored.
REQ-023 commit_we=1 in the cycle after a valid slot DEPTH-1 leaves on advance; otherwise 0.
REQ-024 flush=1: all slot valid bits clear next cycle; in_valid ignored; if advance=1 the slot DEPTH-1 entry still commits (past exception point).
REQ-025 Read merge: start v=cp0_val; if commit_we and address/select match, v=(v&~commit_mask)|(commit_data&commit_mask); then for slots DEPTH-1 down to 0, each valid matching slot applies same merge; rd_val=v.
REQ-026 Match = addr equal AND sel equal AND source valid; younger sources override older only in their masked bits.
REQ-027 rd_hit = OR of all matches; with no match rd_val=cp0_val exactly.
REQ-028 pending_cnt reflects slot valid bits after each edge; range 0..DEPTH.
REQ-029 in_mask=0 with in_valid=1 occupies a slot and commits with mask 0; merge unchanged.
REQ-030 No back-pressure: pipeline guarantees one entry per advance; no overflow condition exists.

Reset
REQ-031 rst_n low clears all slot valid bits, commit_we, pending_cnt to 0; addr/sel/data/mask fields and commit fields to 0, immediately and independent of clk.
REQ-032 Reset asserted mid-operation discards all in-flight entries with no commit issued.
REQ-033 First edge after rst_n rises operates normally.

Structure
REQ-034 Slot record fields, CP0 address/select widths and DATA_W default live in the shared CPU package.
REQ-035 One sub-module, cp0_mask_merge (single masked merge v,data,mask,hit -> v'), instantiated DEPTH+1 times in a chain.
REQ-036 Replaces the fixed three-source CP0 bypass mux in the ID stage.

Verification
REQ-037 Reset, cp0_val=0x1234_5678, read reg12/sel0 -> rd_val=0x1234_5678, rd_hit=0, pending_cnt=0, commit_we=0.
REQ-038 Write reg12/sel0 data=0xFFFF_FFFF mask=0x0000_00FF, advance each cycle, cp0_val=0 -> rd_val=0x0000_00FF for DEPTH+1 cycles; commit_we=1 exactly once, DEPTH cycles after capture.
REQ-039 Two back-to-back writes reg12: older data=0xAAAA_AAAA mask=0xFFFF_0000, younger data=0x5555_5555 mask=0x0000_FFFF, cp0_val=0 -> rd_val=0xAAAA_5555.
REQ-040 Same register, two overlapping masks 0xFFFF_FFFF, older 0x1, younger 0x2 -> rd_val=0x2.
REQ-041 Fill DEPTH slots, pulse flush with advance=1 -> oldest commits, pending_cnt=0 next cycle, rd_hit=0.
REQ-042 Hold advance=0 for 5 cycles with 2 entries pending -> pending_cnt=2 constant, commit_we=0; assert rst_n low mid-hold -> all outputs 0 asynchronously.
